slice_period_timer: RTL and testbench

//  Programmable periodic / one-shot timer that drives the 4-bit synchronous counter slices of a mapped counter chain.
//  A prescaler strobes a WIDTH-bit up-counter built from counter4_slice instances with a ripple-carry ENT chain.
//  The counter compares against a period value, pulses tick on match and reloads through the slices' synchronous load.

---
 rtl/slice_timer_pkg.sv | 16 +
 rtl/counter4_slice.sv | 26 ++
 rtl/slice_period_timer.sv | 152 +++++++++++++++
 tb/tb_slice_period_timer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_timer_pkg.sv
// rtl/slice_timer_pkg.sv - shared types and constants for the slice period timer
package slice_timer_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

    function automatic bit width_ok(input int w);
        return (w > 0) && ((w % SLICE_W) == 0);
    endfunction

endpackage

// File: rtl/counter4_slice.sv
// rtl/counter4_slice.sv - 4-bit synchronous counter slice with load and ripple-carry enable
module counter4_slice
    import slice_timer_pkg::*;
(
    input  logic               clk,
    input  logic               load,
    input  logic [SLICE_W-1:0] d,
    input  logic               ent,
    output logic [SLICE_W-1:0] q,
    output logic               rco
);

    logic [SLICE_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (load) begin
            r_q <= d;
        end else if (ent) begin
            r_q <= r_q + SLICE_W'(1);
        end
    end

    assign q   = r_q;
    assign rco = ent & (r_q == {SLICE_W{1'b1}});

endmodule

// File: rtl/slice_period_timer.sv
// rtl/slice_period_timer.sv - periodic/one-shot timer built on a chain of 4-bit counter slices
module slice_period_timer
    import slice_timer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_presc,
    input  logic                  cfg_oneshot,
    input  logic                  start,
    input  logic                  stop,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  busy
);

    localparam int N_SLICES = WIDTH / SLICE_W;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("slice_period_timer: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    timer_state_t          r_state;
    logic [WIDTH-1:0]      r_period;
    logic [WIDTH-1:0]      r_sh_period;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_sh_presc;
    logic [PRESCALE_W-1:0] r_prescaler;
    logic                  r_oneshot;
    logic                  r_sh_oneshot;
    logic                  r_sh_full;
    logic                  r_tick;

    logic [WIDTH-1:0]      w_count;
    logic [N_SLICES-1:0]   w_ent;
    logic [N_SLICES-1:0]   w_rco;
    logic                  w_run;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_strobe;
    logic                  w_match;
    logic                  w_reload;
    logic                  w_start_entry;
    logic                  w_load;

    assign w_run         = (r_state == ST_RUN);
    assign w_ready       = ~w_run | ~r_sh_full;
    assign w_xfer        = cfg_valid & w_ready;
    assign w_strobe      = w_run & (r_prescaler == r_presc);
    assign w_match       = (w_count == r_period);
    // Terminal carry also forces a reload so the chain can never wrap past all-ones.
    assign w_reload      = w_strobe & (w_match | w_rco[N_SLICES-1]) & ~stop;
    assign w_start_entry = start & ~stop & ~w_run;
    assign w_load        = rst | stop | w_reload | w_start_entry;

    assign w_ent[0] = w_strobe;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
            if (gi > 0) begin : g_chain
                assign w_ent[gi] = w_rco[gi-1];
            end
            counter4_slice u_slice (
                .clk  (clk),
                .load (w_load),
                .d    ({SLICE_W{1'b0}}),
                .ent  (w_ent[gi]),
                .q    (w_count[gi*SLICE_W +: SLICE_W]),
                .rco  (w_rco[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_period     <= '0;
            r_presc      <= '0;
            r_oneshot    <= 1'b0;
            r_sh_period  <= '0;
            r_sh_presc   <= '0;
            r_sh_oneshot <= 1'b0;
            r_sh_full    <= 1'b0;
            r_prescaler  <= '0;
            r_tick       <= 1'b0;
        end else begin
            r_tick <= w_reload;
            if (stop) begin
                // Stop wins over start and tick; any pending shadow config is dropped.
                r_state     <= ST_IDLE;
                r_prescaler <= '0;
                r_sh_full   <= 1'b0;
                if (!w_run && w_xfer) begin
                    r_period  <= cfg_period;
                    r_presc   <= cfg_presc;
                    r_oneshot <= cfg_oneshot;
                end
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_xfer) begin
                            r_period  <= cfg_period;
                            r_presc   <= cfg_presc;
                            r_oneshot <= cfg_oneshot;
                        end
                        if (start) begin
                            r_state     <= ST_RUN;
                            r_prescaler <= '0;
                        end
                    end
                    ST_RUN: begin
                        r_prescaler <= w_strobe ? '0 : r_prescaler + PRESCALE_W'(1);
                        if (w_reload) begin
                            if (r_oneshot) begin
                                r_state <= ST_DONE;
                            end
                            if (r_sh_full) begin
                                r_period  <= r_sh_period;
                                r_presc   <= r_sh_presc;
                                r_oneshot <= r_sh_oneshot;
                                r_sh_full <= 1'b0;
                            end
                        end
                        if (w_xfer) begin
                            r_sh_period  <= cfg_period;
                            r_sh_presc   <= cfg_presc;
                            r_sh_oneshot <= cfg_oneshot;
                            r_sh_full    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_ready = w_ready;
    assign count     = w_count;
    assign tick      = r_tick;
    assign busy      = w_run;

endmodule

// File: tb/tb_slice_period_timer.sv
// tb/tb_slice_period_timer.sv - directed and randomized checks against a behavioural timer model
module tb_slice_period_timer;

    localparam int WIDTH = 16;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic [PW-1:0]    cfg_presc;
    logic             cfg_oneshot;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int period;
        int presc;
        bit oneshot;
    } cfg_t;

    // Model state: 0 = idle, 1 = running, 2 = done
    int   m_state;
    int   m_count;
    int   m_phase;
    bit   m_tick;
    cfg_t m_cfg;
    cfg_t m_shadow[$];

    slice_period_timer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_presc   (cfg_presc),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
        .count       (count),
        .tick        (tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (m_state != 1) || (m_shadow.size() == 0);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_phase = 0;
        m_tick  = 1'b0;
        m_cfg   = '{period: 0, presc: 0, oneshot: 1'b0};
        m_shadow.delete();
    endtask

    task automatic model_edge();
        cfg_t c;
        bit   xfer;
        bit   strobe;
        c.period  = int'(cfg_period);
        c.presc   = int'(cfg_presc);
        c.oneshot = cfg_oneshot;
        xfer      = cfg_valid && m_ready();
        m_tick    = 1'b0;
        if (rst) begin
            model_reset();
        end else if (stop) begin
            if (m_state != 1 && xfer) m_cfg = c;
            m_state = 0;
            m_count = 0;
            m_phase = 0;
            m_shadow.delete();
        end else if (m_state != 1) begin
            if (xfer) m_cfg = c;
            if (start) begin
                m_state = 1;
                m_count = 0;
                m_phase = 0;
            end
        end else begin
            strobe  = (m_phase == m_cfg.presc);
            m_phase = strobe ? 0 : m_phase + 1;
            if (strobe) begin
                if (m_count == m_cfg.period) begin
                    m_count = 0;
                    m_tick  = 1'b1;
                    if (m_cfg.oneshot) m_state = 2;
                    if (m_shadow.size() > 0) m_cfg = m_shadow.pop_front();
                end else begin
                    m_count++;
                end
            end
            if (xfer) m_shadow.push_back(c);
        end
    endtask

    task automatic step();
        check_eq("cfg_ready_pre", {31'd0, cfg_ready}, {31'd0, m_ready()});
        model_edge();
        @(posedge clk);
        #1;
        check_eq("count", {16'd0, count}, m_count);
        check_eq("tick", {31'd0, tick}, {31'd0, m_tick});
        check_eq("busy", {31'd0, busy}, {31'd0, m_state == 1});
        rst       = 1'b0;
        stop      = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic configure(input int period, input int presc, input bit oneshot);
        cfg_valid   = 1'b1;
        cfg_period  = WIDTH'(period);
        cfg_presc   = PW'(presc);
        cfg_oneshot = oneshot;
    endtask

    initial begin
        int n_ticks;
        rst = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_presc = '0;
        cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        step();
        check_eq("reset_ready", {31'd0, cfg_ready}, 32'd1);
        check_eq("reset_count", {16'd0, count}, 32'd0);

        // period 3, presc 0, config and start in the same idle cycle
        configure(3, 0, 1'b0);
        start = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            step();
            check_eq("t1_tick", {31'd0, tick}, {31'd0, (c % 4) == 0});
            check_eq("t1_count", {16'd0, count}, c % 4);
        end
        stop = 1'b1;
        step();

        // period 2, presc 2: one tick every 9 cycles
        configure(2, 2, 1'b0);
        start = 1'b1;
        step();
        n_ticks = 0;
        for (int c = 1; c <= 27; c++) begin
            step();
            if (tick) n_ticks++;
        end
        check_eq("t2_ticks", n_ticks, 32'd3);
        check_eq("t2_tick_at_27", {31'd0, tick}, 32'd1);
        stop = 1'b1;
        step();

        // one-shot period 5
        configure(5, 0, 1'b1);
        start = 1'b1;
        step();
        for (int c = 1; c <= 6; c++) step();
        check_eq("t3_tick", {31'd0, tick}, 32'd1);
        check_eq("t3_busy", {31'd0, busy}, 32'd0);
        check_eq("t3_count", {16'd0, count}, 32'd0);
        for (int c = 0; c < 3; c++) step();
        check_eq("t3_no_retick", {31'd0, tick}, 32'd0);
        start = 1'b1;
        step();
        for (int c = 1; c <= 6; c++) step();
        check_eq("t3_rerun_tick", {31'd0, tick}, 32'd1);
        stop = 1'b1;
        step();

        // mid-period reconfiguration goes through the shadow
        configure(7, 0, 1'b0);
        start = 1'b1;
        step();
        for (int c = 0; c < 3; c++) step();
        configure(1, 0, 1'b0);
        step();
        check_eq("t4_ready_low", {31'd0, cfg_ready}, 32'd0);
        for (int c = 0; c < 20; c++) step();
        stop = 1'b1;
        step();

        // carry across slices, then stop mid-count
        configure(16'h00FF, 0, 1'b0);
        start = 1'b1;
        step();
        for (int c = 1; c <= 256; c++) step();
        check_eq("t5_tick_256", {31'd0, tick}, 32'd1);
        for (int c = 1; c <= 128; c++) step();
        check_eq("t5_count_80", {16'd0, count}, 32'h80);
        stop = 1'b1;
        step();
        check_eq("t5_stop_count", {16'd0, count}, 32'd0);
        check_eq("t5_stop_tick", {31'd0, tick}, 32'd0);

        // reset and stop coinciding with a match
        configure(3, 0, 1'b0);
        start = 1'b1;
        step();
        for (int c = 0; c < 3; c++) step();
        rst = 1'b1;
        step();
        check_eq("t6_rst_tick", {31'd0, tick}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_rst_ready", {31'd0, cfg_ready}, 32'd1);
        configure(3, 0, 1'b0);
        start = 1'b1;
        step();
        for (int c = 0; c < 3; c++) step();
        stop = 1'b1;
        step();
        check_eq("t6_stop_tick", {31'd0, tick}, 32'd0);
        check_eq("t6_stop_count", {16'd0, count}, 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            start       = ($urandom_range(0, 9) == 0);
            cfg_valid   = ($urandom_range(0, 5) == 0);
            cfg_period  = WIDTH'($urandom_range(0, 10));
            cfg_presc   = PW'($urandom_range(0, 3));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
